// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle RV32I data-memory responder with valid/ready
// request handshake, programmable wait states and a single-cycle response.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] LAT    = 4'(LATENCY);

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [2:0]    r_funct3;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_access;
    logic          w_we;
    logic [2:0]    w_f3;
    logic [AW+1:0] w_addr;
    logic [31:0]   w_wdata;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [31:0]   w_shift;
    logic [15:0]   w_half;
    logic [31:0]   w_ld;
    logic          w_f3_ok;
    logic          w_mis;
    logic          w_err;
    logic [3:0]    w_be;
    logic [31:0]   w_wd;
    logic          w_wen;
    logic          w_unused;

    // With zero latency the access happens on the accept edge, so the live
    // request fields are used in IDLE and the captured ones afterwards.
    assign w_accept = (r_state == S_IDLE) & req_valid;
    assign w_access = (w_accept & (LAT == 4'd0)) | ((r_state == S_WAIT) & (r_cnt == 4'd0));
    assign w_we     = (r_state == S_IDLE) ? req_we : r_we;
    assign w_f3     = (r_state == S_IDLE) ? req_funct3 : r_funct3;
    assign w_addr   = (r_state == S_IDLE) ? req_addr[AW+1:0] : r_addr;
    assign w_wdata  = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_unused = &{1'b0, req_addr[31:AW+2]};

    assign w_idx   = w_addr[AW+1:2];
    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_addr[1:0], 3'b000};
    assign w_half  = w_addr[1] ? w_word[31:16] : w_word[15:0];
    assign w_ld    = w_f3[1] ? w_word
                   : w_f3[0] ? {{16{~w_f3[2] & w_half[15]}}, w_half}
                   : {{24{~w_f3[2] & w_shift[7]}}, w_shift[7:0]};

    assign w_f3_ok = (w_f3[1:0] != 2'b11) & (w_we ? ~w_f3[2] : ~(w_f3[2] & w_f3[1]));
    assign w_mis   = ((w_f3[1:0] == 2'b01) & w_addr[0]) |
                     ((w_f3[1:0] == 2'b10) & (w_addr[1:0] != 2'b00));
    assign w_err   = ~w_f3_ok | w_mis;

    assign w_be  = (w_f3[1:0] == 2'b00) ? (4'b0001 << w_addr[1:0])
                 : (w_f3[1:0] == 2'b01) ? (w_addr[1] ? 4'b1100 : 4'b0011)
                 : 4'b1111;
    assign w_wd  = (w_f3[1:0] == 2'b00) ? {4{w_wdata[7:0]}}
                 : (w_f3[1:0] == 2'b01) ? {2{w_wdata[15:0]}}
                 : w_wdata;
    assign w_wen = w_access & w_we & ~w_err & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                if (req_valid) begin
                    r_we     <= req_we;
                    r_funct3 <= req_funct3;
                    r_addr   <= req_addr[AW+1:0];
                    r_wdata  <= req_wdata;
                    // Loaded one below LATENCY so the access edge lands at accept+LATENCY.
                    r_cnt    <= (LAT == 4'd0) ? 4'd0 : LAT - 4'd1;
                    r_state  <= (LAT == 4'd0) ? S_RESP : S_WAIT;
                end
            end else if (r_state == S_WAIT) begin
                if (r_cnt == 4'd0)
                    r_state <= S_RESP;
                else
                    r_cnt <= r_cnt - 4'd1;
            end else begin
                r_state <= S_IDLE;
            end
            if (w_access) begin
                r_rdata <= (w_err | w_we) ? 32'd0 : w_ld;
                r_err   <= w_err;
            end
        end
    end

    // Storage is deliberately outside the reset domain; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wen) begin
            for (int b = 0; b < 4; b++)
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign stall     = req_valid & ~rsp_valid;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for dmem_responder, with a
// LATENCY=2 instance (a_*) and a LATENCY=0 instance (b_*).
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_req_valid = 1'b0, a_req_we = 1'b0;
    logic [2:0]  a_req_funct3 = 3'd0;
    logic [31:0] a_req_addr = 32'd0, a_req_wdata = 32'd0;
    logic        a_req_ready, a_rsp_valid, a_rsp_err, a_stall;
    logic [31:0] a_rsp_rdata;
    logic        b_req_valid = 1'b0, b_req_we = 1'b0;
    logic [2:0]  b_req_funct3 = 3'd0;
    logic [31:0] b_req_addr = 32'd0, b_req_wdata = 32'd0;
    logic        b_req_ready, b_rsp_valid, b_rsp_err, b_stall;
    logic [31:0] b_rsp_rdata;
    logic [32:0] sbq[$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_a (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .req_funct3(a_req_funct3), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .stall(a_stall)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_funct3(b_req_funct3), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .stall(b_stall)
    );

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request starting at a negedge, checks latency, stall span,
    // the scoreboarded response and the single-cycle pulse; ends at a negedge in IDLE.
    task automatic req(input bit sel, input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic err_e, input logic [31:0] rd_e);
        int n = 0;
        int st = 0;
        int lat = sel ? 0 : 2;
        logic rv = 1'b0;
        logic [32:0] e;
        chk({tag, ".ready"}, {32'd0, sel ? b_req_ready : a_req_ready}, 33'd1);
        if (sel) begin
            b_req_valid = 1'b1; b_req_we = we; b_req_funct3 = f3; b_req_addr = addr; b_req_wdata = wd;
        end else begin
            a_req_valid = 1'b1; a_req_we = we; a_req_funct3 = f3; a_req_addr = addr; a_req_wdata = wd;
        end
        sbq.push_back({err_e, rd_e});
        #1 st = int'(sel ? b_stall : a_stall);
        while (n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            rv = sel ? b_rsp_valid : a_rsp_valid;
            if (rv) break;
            st += int'(sel ? b_stall : a_stall);
        end
        chk({tag, ".lat"}, 33'(n), 33'(lat + 1));
        chk({tag, ".stall"}, 33'(st), 33'(lat + 1));
        if (rv) begin
            e = sbq.pop_front();
            chk({tag, ".rsp"}, sel ? {b_rsp_err, b_rsp_rdata} : {a_rsp_err, a_rsp_rdata}, e);
        end else begin
            void'(sbq.pop_front());
        end
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".pulse"}, {32'd0, sel ? b_rsp_valid : a_rsp_valid}, 33'd0);
    endtask

    initial begin
        int nrv;
        a_req_valid = 1'b1;
        #2;
        chk("rst.stall_hi", {32'd0, a_stall}, 33'd1);
        chk("rst.ready", {32'd0, a_req_ready}, 33'd1);
        chk("rst.rsp", {a_rsp_valid, a_rsp_err, a_rsp_rdata[30:0]}, 33'd0);
        chk("rst.rdata", {1'b0, a_rsp_rdata}, 33'd0);
        a_req_valid = 1'b0;
        #1 chk("rst.stall_lo", {32'd0, a_stall}, 33'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        req(0, "sw10",   1, 3'b010, 32'h10,  32'hDEADBEEF, 0, 32'h0);
        req(0, "lw10",   0, 3'b010, 32'h10,  32'h0,        0, 32'hDEADBEEF);
        req(0, "sb13",   1, 3'b000, 32'h13,  32'h80,       0, 32'h0);
        req(0, "lb13",   0, 3'b000, 32'h13,  32'h0,        0, 32'hFFFFFF80);
        req(0, "lbu13",  0, 3'b100, 32'h13,  32'h0,        0, 32'h00000080);
        req(0, "lw10b",  0, 3'b010, 32'h10,  32'h0,        0, 32'h80ADBEEF);
        req(0, "sw20",   1, 3'b010, 32'h20,  32'h12345678, 0, 32'h0);
        req(0, "sh22",   1, 3'b001, 32'h22,  32'h8001,     0, 32'h0);
        req(0, "lh22",   0, 3'b001, 32'h22,  32'h0,        0, 32'hFFFF8001);
        req(0, "lhu22",  0, 3'b101, 32'h22,  32'h0,        0, 32'h00008001);
        req(0, "lh20",   0, 3'b001, 32'h20,  32'h0,        0, 32'h00005678);
        req(0, "lw11",   0, 3'b010, 32'h11,  32'h0,        1, 32'h0);
        req(0, "sh23",   1, 3'b001, 32'h23,  32'hBEEF,     1, 32'h0);
        req(0, "lw20c",  0, 3'b010, 32'h20,  32'h0,        0, 32'h80015678);
        req(0, "s011",   1, 3'b011, 32'h10,  32'h0,        1, 32'h0);
        req(0, "l110",   0, 3'b110, 32'h10,  32'h0,        1, 32'h0);
        req(0, "lw10c",  0, 3'b010, 32'h10,  32'h0,        0, 32'h80ADBEEF);
        req(0, "sw400",  1, 3'b010, 32'h400, 32'h12345678, 0, 32'h0);
        req(0, "lw0",    0, 3'b010, 32'h0,   32'h0,        0, 32'h12345678);

        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_funct3 = 3'b010;
        a_req_addr = 32'h10; a_req_wdata = 32'hAAAAAAAA;
        @(posedge clk);
        @(negedge clk);
        chk("abort.accepted", {32'd0, a_req_ready}, 33'd0);
        rst = 1'b0;
        a_req_valid = 1'b0;
        nrv = 0;
        repeat (4) begin
            @(negedge clk);
            nrv += int'(a_rsp_valid) + int'(b_rsp_valid);
        end
        chk("abort.norsp", 33'(nrv), 33'd0);
        rst = 1'b1;
        #1 chk("abort.ready", {31'd0, a_req_ready, b_req_ready}, 33'd3);
        @(negedge clk);
        req(0, "lw10d",  0, 3'b010, 32'h10,  32'h0,        0, 32'h80ADBEEF);

        req(1, "b.sw8",  1, 3'b010, 32'h8,   32'h55AA00FF, 0, 32'h0);
        req(1, "b.lw8",  0, 3'b010, 32'h8,   32'h0,        0, 32'h55AA00FF);
        req(1, "b.lb8",  0, 3'b000, 32'h8,   32'h0,        0, 32'hFFFFFFFF);
        req(1, "b.lhua", 0, 3'b101, 32'hA,   32'h0,        0, 32'h000055AA);
        req(1, "b.lw9",  0, 3'b010, 32'h9,   32'h0,        1, 32'h0);
        req(1, "b.lw8b", 0, 3'b010, 32'h8,   32'h0,        0, 32'h55AA00FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
